// File: rtl/mem_bringup_sequencer.sv
// DDR bring-up sequencer: MIG reset, MMCM-lock/calibration supervision with timeouts and bounded retry.
// Build option: MEM_SEQ_AUTO_RECOVER_EN makes a fault in RUN re-run bring-up instead of failing.
module mem_bringup_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned CALIB_TIMEOUT = 4194304,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clock,
  input  logic       sys_reset,
  input  logic       clock_ok,
  input  logic       mmcm_locked,
  input  logic       calib_complete,
  input  logic       ui_clk_sync_rst,
  output logic       mem_reset,
  output logic       aresetn,
  output logic       mem_ok,
  output logic       mem_error,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  localparam int unsigned MAX_A = (LOCK_TIMEOUT > CALIB_TIMEOUT) ? LOCK_TIMEOUT : CALIB_TIMEOUT;
  localparam int unsigned MAX_B = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_T) + 1;

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_WAIT_CALIB = 3'd2,
    S_SETTLE     = 3'd3,
    S_RUN        = 3'd4,
    S_RETRY      = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  // Bit order in each stage: {clock_ok, mmcm_locked, calib_complete, ui_clk_sync_rst}
  (* ASYNC_REG = "TRUE" *) logic [3:0] sync1;
  (* ASYNC_REG = "TRUE" *) logic [3:0] sync2;
  (* ASYNC_REG = "TRUE" *) logic [3:0] sync3;

  logic clock_ok_s, mmcm_locked_s, calib_complete_s, ui_clk_sync_rst_s;
  logic link_fault;

  state_t        state_q, state_next;
  logic [CW-1:0] cnt_q, cnt_next;
  logic [3:0]    retry_q, retry_next;

  always_ff @(posedge clock) begin
    sync1 <= {clock_ok, mmcm_locked, calib_complete, ui_clk_sync_rst};
    sync2 <= sync1;
    sync3 <= sync2;
  end

  assign {clock_ok_s, mmcm_locked_s, calib_complete_s, ui_clk_sync_rst_s} = sync3;
  assign link_fault = !mmcm_locked_s || !calib_complete_s || ui_clk_sync_rst_s;

  always_comb begin
    state_next = state_q;
    retry_next = retry_q;
    cnt_next   = '0;
    if (!clock_ok_s && state_q != S_HOLD && state_q != S_FAIL) begin
      state_next = S_HOLD;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (clock_ok_s && cnt_q == CW'(RESET_CYCLES - 1)) state_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (mmcm_locked_s)                             state_next = S_WAIT_CALIB;
          else if (cnt_q == CW'(LOCK_TIMEOUT - 1))       state_next = S_RETRY;
        end
        S_WAIT_CALIB: begin
          if (!mmcm_locked_s)                            state_next = S_RETRY;
          else if (calib_complete_s && !ui_clk_sync_rst_s) state_next = S_SETTLE;
          else if (cnt_q == CW'(CALIB_TIMEOUT - 1))      state_next = S_RETRY;
        end
        S_SETTLE: begin
          if (link_fault)                                state_next = S_RETRY;
          else if (cnt_q == CW'(SETTLE_CYCLES - 1))      state_next = S_RUN;
        end
        S_RUN: begin
`ifdef MEM_SEQ_AUTO_RECOVER_EN
          if (link_fault) state_next = S_RETRY;
`else
          if (link_fault) state_next = S_FAIL;
`endif
        end
        S_RETRY: begin
          if (retry_q == 4'(MAX_RETRY)) begin
            state_next = S_FAIL;
          end else begin
            retry_next = retry_q + 4'd1;
            state_next = S_HOLD;
          end
        end
        S_FAIL:  state_next = S_FAIL;
        default: state_next = S_HOLD;
      endcase
    end

    // HOLD counts consecutive clock_ok cycles; timed states count dwell; others park at zero
    if (state_next != state_q)                                         cnt_next = '0;
    else if (state_q == S_HOLD)                                        cnt_next = clock_ok_s ? cnt_q + CW'(1) : '0;
    else if (state_q inside {S_WAIT_LOCK, S_WAIT_CALIB, S_SETTLE})     cnt_next = cnt_q + CW'(1);
  end

  // Outputs are decoded from the current state, so they follow a state change by one cycle
  always_ff @(posedge clock) begin
    if (sys_reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      mem_reset <= 1'b1;
      aresetn   <= 1'b0;
      mem_ok    <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      retry_q   <= retry_next;
      mem_reset <= !(state_q inside {S_WAIT_LOCK, S_WAIT_CALIB, S_SETTLE, S_RUN});
      aresetn   <= (state_q == S_RUN);
      mem_ok    <= (state_q == S_RUN);
      mem_error <= (state_q == S_FAIL);
    end
  end

  assign state       = state_q;
  assign retry_count = retry_q;

endmodule
